// File: rtl/banco_reg_pkg.sv
// Shared constants, priority encoding and helpers for the register file.
// Define BANCO_REG_BYPASS_EN to enable write-to-read forwarding on both read ports.
package banco_reg_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 8;

   // Per-edge operation, highest priority wins: rst > clr > we
   localparam logic [1:0] OP_IDLE = 2'd0;
   localparam logic [1:0] OP_WR   = 2'd1;
   localparam logic [1:0] OP_CLR  = 2'd2;
   localparam logic [1:0] OP_RST  = 2'd3;

`ifdef BANCO_REG_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   function automatic int clog2(input int value);
      int r;
      for (r = 0; (1 << r) < value; r++) begin
      end
      return r;
   endfunction

   function automatic logic [1:0] prio_op(input logic rst, input logic clr, input logic we);
      if (rst)      return OP_RST;
      else if (clr) return OP_CLR;
      else if (we)  return OP_WR;
      else          return OP_IDLE;
   endfunction

endpackage

// File: rtl/banco_registradores_porta_leitura.sv
// One registered read port: range-checked entry select, optional forwarding
// of the in-flight write, and the output register.
module porta_leitura_reg
   import banco_reg_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = clog2(DEFAULT_DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
   input  logic [ADDR_W-1:0]            raddr,
   input  logic                         fwd_vld,
   input  logic [ADDR_W-1:0]            waddr,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata
);

   logic [WIDTH-1:0] rdata_d, rdata_q;

   // Addresses past DEPTH match no entry and read back as zero
   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr == ADDR_W'(i)) rdata_d = mem[i];
      end
      if (BYPASS_EN && fwd_vld && (raddr == waddr)) rdata_d = wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/banco_registradores.sv
// DEPTH x WIDTH register file: one write port, two registered read ports,
// per-entry valid flags, synchronous clear and out-of-range write detection.
// Optional forwarding is enabled with BANCO_REG_BYPASS_EN.
module banco_registradores
   import banco_reg_pkg::*;
#(
   parameter int  WIDTH  = DEFAULT_WIDTH,
   parameter int  DEPTH  = DEFAULT_DEPTH,
   localparam int ADDR_W = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_a,
   output logic [WIDTH-1:0]  rdata_b,
   output logic [DEPTH-1:0]  valid,
   output logic              err
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_d, mem_q;
   logic [DEPTH-1:0]            valid_d, valid_q;
   logic                        err_d, err_q;
   logic                        wr_in_range;
   logic                        fwd_vld;

   always_comb begin
      mem_d       = mem_q;
      valid_d     = valid_q;
      err_d       = 1'b0;
      wr_in_range = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (waddr == ADDR_W'(i)) wr_in_range = 1'b1;
      end
      case (prio_op(rst, clr, we))
         OP_RST, OP_CLR: begin
            mem_d   = '0;
            valid_d = '0;
         end
         OP_WR: begin
            if (wr_in_range) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (waddr == ADDR_W'(i)) begin
                     mem_d[i]   = wdata;
                     valid_d[i] = 1'b1;
                  end
               end
            end else begin
               err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '0;
         valid_q <= '0;
         err_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // A clear discards the write, so nothing may be forwarded in that cycle
   assign fwd_vld = we & ~clr & wr_in_range;

   porta_leitura_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_porta_a (
      .clk     (clk),
      .rst     (rst),
      .mem     (mem_q),
      .raddr   (raddr_a),
      .fwd_vld (fwd_vld),
      .waddr   (waddr),
      .wdata   (wdata),
      .rdata   (rdata_a)
   );

   porta_leitura_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_porta_b (
      .clk     (clk),
      .rst     (rst),
      .mem     (mem_q),
      .raddr   (raddr_b),
      .fwd_vld (fwd_vld),
      .waddr   (waddr),
      .wdata   (wdata),
      .rdata   (rdata_b)
   );

   assign valid = valid_q;
   assign err   = err_q;

endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench: DEPTH=8 instance for the main function, DEPTH=6 instance
// (same stimulus) for out-of-range write handling.
module tb_banco_registradores;

   logic        clk = 1'b0;
   logic        rst, clr, we;
   logic [2:0]  waddr, raddr_a, raddr_b;
   logic [15:0] wdata;

   logic [15:0] rd_a8, rd_b8, rd_a6, rd_b6;
   logic [7:0]  valid8;
   logic [5:0]  valid6;
   logic        err8, err6;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   banco_registradores #(.WIDTH(16), .DEPTH(8)) dut8 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a8), .rdata_b(rd_b8),
      .valid(valid8), .err(err8)
   );

   banco_registradores #(.WIDTH(16), .DEPTH(6)) dut6 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a6), .rdata_b(rd_b6),
      .valid(valid6), .err(err6)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      raddr_a = '0; raddr_b = '0;
      step(); step();
      rst = 1'b0;
      for (int a = 0; a < 8; a++) begin
         raddr_a = a[2:0];
         raddr_b = 3'(7 - a);
         step();
         checks++;
         if (rd_a8 !== 16'h0000 || rd_b8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_read addr %0d: got a=%h b=%h expected 0000", a, rd_a8, rd_b8);
         end
      end
      checks++;
      if (valid8 !== 8'h00 || err8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got valid=%h err=%b expected 00/0", valid8, err8);
      end
      checks++;
      if (valid6 !== 6'h00 || err6 !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags6: got valid=%h err=%b expected 00/0", valid6, err6);
      end
   endtask

   task automatic test_write_read();
      we = 1'b1; waddr = 3'd3; wdata = 16'h0004;
      step();
      waddr = 3'd5; wdata = 16'h0002;
      step();
      we = 1'b0; raddr_a = 3'd3; raddr_b = 3'd5;
      step();
      checks++;
      if (rd_a8 !== 16'h0004) begin
         errors++;
         $display("FAIL wr_rd_a: got %h expected 0004", rd_a8);
      end
      checks++;
      if (rd_b8 !== 16'h0002) begin
         errors++;
         $display("FAIL wr_rd_b: got %h expected 0002", rd_b8);
      end
      checks++;
      if (valid8 !== 8'b0010_1000) begin
         errors++;
         $display("FAIL wr_valid: got %b expected 00101000", valid8);
      end
      checks++;
      if (valid6 !== 6'b10_1000 || err6 !== 1'b0) begin
         errors++;
         $display("FAIL wr_valid6: got %b err=%b expected 101000/0", valid6, err6);
      end
   endtask

   task automatic test_same_cycle();
      logic [15:0] exp_a;
`ifdef BANCO_REG_BYPASS_EN
      exp_a = 16'h0008;
`else
      exp_a = 16'h0004;
`endif
      we = 1'b1; waddr = 3'd3; wdata = 16'h0008; raddr_a = 3'd3; raddr_b = 3'd5;
      step();
      checks++;
      if (rd_a8 !== exp_a || rd_b8 !== 16'h0002) begin
         errors++;
         $display("FAIL same_cycle: got a=%h b=%h expected a=%h b=0002", rd_a8, rd_b8, exp_a);
      end
      we = 1'b0;
      step();
      checks++;
      if (rd_a8 !== 16'h0008) begin
         errors++;
         $display("FAIL same_cycle_next: got %h expected 0008", rd_a8);
      end
   endtask

   task automatic test_clear();
      clr = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 16'hABCD; raddr_a = 3'd3; raddr_b = 3'd1;
      step();
      checks++;
      if (rd_a8 !== 16'h0008 || rd_b8 !== 16'h0000) begin
         errors++;
         $display("FAIL clr_read_pre: got a=%h b=%h expected a=0008 b=0000", rd_a8, rd_b8);
      end
      checks++;
      if (valid8 !== 8'h00 || valid6 !== 6'h00 || err8 !== 1'b0) begin
         errors++;
         $display("FAIL clr_valid: got %h/%h err=%b expected 00/00/0", valid8, valid6, err8);
      end
      clr = 1'b0; we = 1'b0;
      step();
      checks++;
      if (rd_a8 !== 16'h0000 || rd_b8 !== 16'h0000) begin
         errors++;
         $display("FAIL clr_read_post: got a=%h b=%h expected 0000", rd_a8, rd_b8);
      end
   endtask

   task automatic test_out_of_range();
      we = 1'b1; waddr = 3'd2; wdata = 16'h0055;
      step();
      waddr = 3'd7; wdata = 16'hFFFF; raddr_a = 3'd7; raddr_b = 3'd2;
      step();
      checks++;
      if (err6 !== 1'b1 || err8 !== 1'b0) begin
         errors++;
         $display("FAIL oor_err_pulse: got err6=%b err8=%b expected 1/0", err6, err8);
      end
      checks++;
      if (valid6 !== 6'b00_0100 || valid8 !== 8'h84) begin
         errors++;
         $display("FAIL oor_valid: got %b/%h expected 000100/84", valid6, valid8);
      end
      checks++;
      if (rd_a6 !== 16'h0000 || rd_b6 !== 16'h0055) begin
         errors++;
         $display("FAIL oor_no_fwd: got a=%h b=%h expected 0000/0055", rd_a6, rd_b6);
      end
      we = 1'b0;
      step();
      checks++;
      if (err6 !== 1'b0 || valid6 !== 6'b00_0100) begin
         errors++;
         $display("FAIL oor_err_drop: got err=%b valid=%b expected 0/000100", err6, valid6);
      end
      checks++;
      if (rd_a6 !== 16'h0000 || rd_a8 !== 16'hFFFF) begin
         errors++;
         $display("FAIL oor_read7: got a6=%h a8=%h expected 0000/FFFF", rd_a6, rd_a8);
      end
      // Boundaries: first out-of-range and last in-range address of DEPTH=6
      we = 1'b1; waddr = 3'd6; wdata = 16'h0066;
      step();
      checks++;
      if (err6 !== 1'b1 || valid6 !== 6'b00_0100) begin
         errors++;
         $display("FAIL oor_addr6: got err=%b valid=%b expected 1/000100", err6, valid6);
      end
      waddr = 3'd5; wdata = 16'h0077;
      step();
      checks++;
      if (err6 !== 1'b0 || valid6 !== 6'b10_0100) begin
         errors++;
         $display("FAIL inrange_addr5: got err=%b valid=%b expected 0/100100", err6, valid6);
      end
      we = 1'b0;
   endtask

   task automatic test_shared_addr();
      raddr_a = 3'd5; raddr_b = 3'd5;
      step();
      checks++;
      if (rd_a6 !== 16'h0077 || rd_b6 !== 16'h0077) begin
         errors++;
         $display("FAIL shared_addr: got a=%h b=%h expected 0077", rd_a6, rd_b6);
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'h1234; raddr_a = 3'd2; raddr_b = 3'd5;
      step();
      checks++;
      if (rd_a8 !== 16'h0000 || rd_b8 !== 16'h0000 || valid8 !== 8'h00 || err8 !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: got a=%h b=%h valid=%h err=%b expected 0", rd_a8, rd_b8, valid8, err8);
      end
      rst = 1'b0; we = 1'b0;
      step();
      checks++;
      if (rd_a8 !== 16'h0000 || rd_b6 !== 16'h0000 || valid6 !== 6'h00) begin
         errors++;
         $display("FAIL rst_mid_after: got a8=%h b6=%h valid6=%h expected 0", rd_a8, rd_b6, valid6);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_same_cycle();
      test_clear();
      test_out_of_range();
      test_shared_addr();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
